key_debounce_pulse: RTL and testbench
=====================================

// Module: key_debounce_pulse
// PURPOSE
//  Turns a raw, bouncing mechanical key into clean one-cycle events for the clock's control logic.
//  Drives the mode-select stepper and the set/adjust key consumers.
//  Pipeline: 2-FF synchroniser, then debounce FSM.
//  Emits press/release pulses, a long-press pulse, and auto-repeat pulses while held (fast time-setting).
// PARAMETERS
//  CLK_FREQ_HZ  50_000_000  system clock frequency
//  DEBOUNCE_MS  20          stable time required to accept a press or release
//  LONG_MS      1000        hold time, from accepted press, before key_long fires
//  REPEAT_MS    200         key_repeat period once long-press is reached
//  ACTIVE_LOW   1           1: key_raw==0 means pressed; 0: key_raw==1 means pressed
//  Derived: DB_CYC/LONG_CYC/REP_CYC = CLK_FREQ_HZ/1000*ms; CNT_W = $clog2(max of the three)+1
// PORTS
//  clk         in   1  system clock
//  rst_n       in   1  asynchronous, active-low reset
//  key_raw     in   1  raw key pin, asynchronous to clk
//  key_press   out  1  one-cycle pulse: debounced press accepted
//  key_release out  1  one-cycle pulse: debounced release accepted
//  key_long    out  1  one-cycle pulse: held LONG_CYC cycles after key_press
//  key_repeat  out  1  one-cycle pulse every REP_CYC cycles after key_long, while held
//  key_level   out  1  debounced level, 1 = pressed
// BEHAVIOUR
//  Reset values:
//   - All outputs are 0; FSM is in IDLE; counter is 0.
//   - Synchroniser FFs hold the "released" raw level (the ACTIVE_LOW value).
//  Synchroniser: 2 FFs; key_s = normalised level (1 = pressed); 2-cycle latency.
//  All pulse outputs are registered. At most one pulse is asserted per cycle.
//  FSM states: IDLE, PRESS_DB, HELD, LONG_HELD, RELEASE_DB.
//   IDLE:
//    - key_s=1 -> PRESS_DB, cnt=0.
//   PRESS_DB:
//    - key_s=0 -> IDLE, no pulse; bounce restarts the whole qualification.
//    - Otherwise cnt++.
//    - key_s=1 at cnt==DB_CYC-1 -> HELD, cnt=0, key_press=1 for that cycle.
//   HELD:
//    - cnt++.
//    - cnt==LONG_CYC-1 -> LONG_HELD, cnt=0, key_long=1.
//    - key_s=0 -> RELEASE_DB, cnt=0, ret=HELD.
//   LONG_HELD:
//    - cnt++.
//    - cnt==REP_CYC-1 -> cnt=0, key_repeat=1; the counter wraps, with no saturation or overflow.
//    - key_s=0 -> RELEASE_DB, cnt=0, ret=LONG_HELD.
//   RELEASE_DB:
//    - key_s=1 -> return to ret, cnt=0; no pulse, and key_long is never re-fired.
//    - key_s=0 at cnt==DB_CYC-1 -> IDLE, key_release=1.
//  key_level:
//   - 1 in HELD, LONG_HELD and RELEASE_DB; 0 in IDLE and PRESS_DB.
//   - Registered, and changes in the same cycle as key_press / key_release.
//  Latency:
//   - Raw edge at cycle 0 with no bounce -> key_press at cycle 2+DB_CYC.
//   - Release follows the same rule -> key_release at cycle 2+DB_CYC.
//  Simultaneous events:
//   - A release sample takes priority over a long/repeat terminal count in the same cycle: no pulse, go to RELEASE_DB.
//  Reset mid-operation:
//   - Immediate return to the reset state; no pulse is emitted.
//   - A key still held after reset is re-qualified from IDLE and yields a fresh key_press.
//  Parameter constraints: DB_CYC, LONG_CYC, REP_CYC must each be >= 2 (checked by an elaboration-time assertion).
// STRUCTURE
//  Shared package / include file:
//   - FSM state encoding localparams (3-bit).
//   - ms-to-cycles constant function, shared with the other clock timers.
//  Sub-module sync_2ff (1-bit, reset value parameter): reused for every pin input in the design.
//  Top contains: the FSM, one shared CNT_W counter, the ret flag, and the output registers.
// TESTING  (bench parameters: CLK_FREQ_HZ=10_000, DEBOUNCE_MS=2, LONG_MS=10, REPEAT_MS=3 -> DB=20, LONG=100, REP=30)
//  1. Clean press at cycle 0, held 60 cycles, clean release:
//     key_press at 22; key_level=1 for cycles 22..(release+21); key_release at release+22.
//  2. Bounce: raw pressed 0..9, released 10..14, pressed from 15 on:
//     no pulse before 37; key_press at 37.
//  3. Glitch: press pulse shorter than 20 cycles:
//     no pulses; key_level stays 0; FSM ends in IDLE.
//  4. Long hold of 200 cycles after key_press:
//     key_long 100 cycles after key_press; key_repeat at +30 and +60 after key_long; no second key_long.
//  5. Release bounce of 5 cycles in LONG_HELD, then re-pressed:
//     no key_release; repeat cadence restarts 30 cycles after return; key_level stays 1.
//  6. rst_n low mid-PRESS_DB and mid-LONG_HELD:
//     all outputs 0 at once; key held through reset -> key_press 22 cycles after rst_n rises.

Source files
------------

// File: rtl/key_debounce_pulse_pkg.sv
// Shared definitions for the key debouncer: FSM state encoding and timer helpers.
// The ms-to-cycles helper is common to all of the clock's millisecond timers.
package key_debounce_pulse_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_PRESS_DB   = 3'd1,
        ST_HELD       = 3'd2,
        ST_LONG_HELD  = 3'd3,
        ST_RELEASE_DB = 3'd4
    } state_t;

    function automatic int ms_to_cycles(input int clk_freq_hz, input int ms);
        return (clk_freq_hz / 1000) * ms;
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous pin; RESET_VAL sets the
// level both flops hold while in reset.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_reg;
    logic sync_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_reg <= RESET_VAL;
            sync_reg <= RESET_VAL;
        end else begin
            meta_reg <= d;
            sync_reg <= meta_reg;
        end
    end

    assign q = sync_reg;

endmodule

// File: rtl/key_debounce_pulse.sv
// Debounces a mechanical key and emits press, release, long-press and
// auto-repeat pulses plus the debounced level.
module key_debounce_pulse
    import key_debounce_pulse_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 50_000_000,
    parameter int DEBOUNCE_MS = 20,
    parameter int LONG_MS     = 1000,
    parameter int REPEAT_MS   = 200,
    parameter int ACTIVE_LOW  = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_raw,
    output logic key_press,
    output logic key_release,
    output logic key_long,
    output logic key_repeat,
    output logic key_level
);

    localparam int   DB_CYC   = ms_to_cycles(CLK_FREQ_HZ, DEBOUNCE_MS);
    localparam int   LONG_CYC = ms_to_cycles(CLK_FREQ_HZ, LONG_MS);
    localparam int   REP_CYC  = ms_to_cycles(CLK_FREQ_HZ, REPEAT_MS);
    localparam int   MAX_CYC  = max3(DB_CYC, LONG_CYC, REP_CYC);
    localparam int   CNT_W    = $clog2(MAX_CYC) + 1;
    localparam logic RAW_IDLE = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

    localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DB_CYC - 1);
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYC - 1);
    localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REP_CYC - 1);

    if (DB_CYC < 2 || LONG_CYC < 2 || REP_CYC < 2) begin : g_bad_params
        $error("key_debounce_pulse: DB_CYC, LONG_CYC and REP_CYC must each be >= 2");
    end

    logic             key_sync;
    logic             key_s;
    state_t           state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             ret_long_reg;
    logic             key_press_reg;
    logic             key_release_reg;
    logic             key_long_reg;
    logic             key_repeat_reg;
    logic             key_level_reg;

    sync_2ff #(
        .RESET_VAL (RAW_IDLE)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (key_raw),
        .q     (key_sync)
    );

    // Normalise polarity so key_s is 1 while pressed.
    assign key_s = key_sync ^ RAW_IDLE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= ST_IDLE;
            cnt_reg         <= '0;
            ret_long_reg    <= 1'b0;
            key_press_reg   <= 1'b0;
            key_release_reg <= 1'b0;
            key_long_reg    <= 1'b0;
            key_repeat_reg  <= 1'b0;
            key_level_reg   <= 1'b0;
        end else begin
            key_press_reg   <= 1'b0;
            key_release_reg <= 1'b0;
            key_long_reg    <= 1'b0;
            key_repeat_reg  <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (key_s) begin
                        state_reg <= ST_PRESS_DB;
                        cnt_reg   <= '0;
                    end
                end
                ST_PRESS_DB: begin
                    if (!key_s) begin
                        state_reg <= ST_IDLE;
                        cnt_reg   <= '0;
                    end else if (cnt_reg == DB_LAST) begin
                        state_reg     <= ST_HELD;
                        cnt_reg       <= '0;
                        key_press_reg <= 1'b1;
                        key_level_reg <= 1'b1;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end
                // A release sample wins over a terminal count in the same cycle.
                ST_HELD: begin
                    if (!key_s) begin
                        state_reg    <= ST_RELEASE_DB;
                        cnt_reg      <= '0;
                        ret_long_reg <= 1'b0;
                    end else if (cnt_reg == LONG_LAST) begin
                        state_reg    <= ST_LONG_HELD;
                        cnt_reg      <= '0;
                        key_long_reg <= 1'b1;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end
                ST_LONG_HELD: begin
                    if (!key_s) begin
                        state_reg    <= ST_RELEASE_DB;
                        cnt_reg      <= '0;
                        ret_long_reg <= 1'b1;
                    end else if (cnt_reg == REP_LAST) begin
                        cnt_reg        <= '0;
                        key_repeat_reg <= 1'b1;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end
                ST_RELEASE_DB: begin
                    if (key_s) begin
                        state_reg <= ret_long_reg ? ST_LONG_HELD : ST_HELD;
                        cnt_reg   <= '0;
                    end else if (cnt_reg == DB_LAST) begin
                        state_reg       <= ST_IDLE;
                        cnt_reg         <= '0;
                        key_release_reg <= 1'b1;
                        key_level_reg   <= 1'b0;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end
                default: begin
                    state_reg     <= ST_IDLE;
                    cnt_reg       <= '0;
                    key_level_reg <= 1'b0;
                end
            endcase
        end
    end

    assign key_press   = key_press_reg;
    assign key_release = key_release_reg;
    assign key_long    = key_long_reg;
    assign key_repeat  = key_repeat_reg;
    assign key_level   = key_level_reg;

endmodule

// File: tb/tb_key_debounce_pulse.sv
// Scoreboard bench for key_debounce_pulse: expected pulses are queued with
// their cycle stamp as stimulus is driven and matched as the DUT emits them.
`timescale 1ns/1ps
module tb_key_debounce_pulse;

    localparam int EV_PRESS   = 0;
    localparam int EV_RELEASE = 1;
    localparam int EV_LONG    = 2;
    localparam int EV_REPEAT  = 3;

    typedef struct {
        int kind;
        int cyc;
    } ev_t;

    logic clk = 1'b0;
    logic rst_n;
    logic key_raw;
    logic key_press;
    logic key_release;
    logic key_long;
    logic key_repeat;
    logic key_level;

    int  edge_cnt = 0;
    int  checks   = 0;
    int  failures = 0;
    ev_t sb_q[$];

    key_debounce_pulse #(
        .CLK_FREQ_HZ (10_000),
        .DEBOUNCE_MS (2),
        .LONG_MS     (10),
        .REPEAT_MS   (3),
        .ACTIVE_LOW  (1)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .key_raw     (key_raw),
        .key_press   (key_press),
        .key_release (key_release),
        .key_long    (key_long),
        .key_repeat  (key_repeat),
        .key_level   (key_level)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    function automatic string ev_name(input int kind);
        case (kind)
            EV_PRESS:   return "press";
            EV_RELEASE: return "release";
            EV_LONG:    return "long";
            default:    return "repeat";
        endcase
    endfunction

    // Pulse monitor: every observed pulse is matched against the scoreboard head.
    initial begin
        logic [3:0] pulses;
        int         kind;
        ev_t        exp_ev;
        forever begin
            @(negedge clk);
            pulses = {key_repeat, key_long, key_release, key_press};
            if (pulses != 4'b0000) begin
                checks++;
                kind = pulses[0] ? EV_PRESS : pulses[1] ? EV_RELEASE :
                       pulses[2] ? EV_LONG : EV_REPEAT;
                if ($countones(pulses) != 1) begin
                    failures++;
                    $display("FAIL one_pulse cycle=%0d pulses=%b required one-hot", edge_cnt, pulses);
                end else if (sb_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_pulse cycle=%0d got=%s required none", edge_cnt, ev_name(kind));
                end else begin
                    exp_ev = sb_q.pop_front();
                    if (kind !== exp_ev.kind || edge_cnt !== exp_ev.cyc)
                        begin
                        failures++;
                        $display("FAIL pulse got=%s@%0d required %s@%0d",
                                 ev_name(kind), edge_cnt, ev_name(exp_ev.kind), exp_ev.cyc);
                    end else begin
                        $display("event %s at cycle %0d ok", ev_name(kind), edge_cnt);
                    end
                end
            end
        end
    end

    task automatic wait_to(input int target);
        while (edge_cnt < target) @(negedge clk);
    endtask

    task automatic push_ev(input int kind, input int cyc);
        ev_t e;
        e.kind = kind;
        e.cyc  = cyc;
        sb_q.push_back(e);
    endtask

    task automatic check_level(input string name, input logic required);
        checks++;
        if (key_level !== required) begin
            failures++;
            $display("FAIL %s cycle=%0d key_level=%b required %b", name, edge_cnt, key_level, required);
        end
    endtask

    task automatic check_drained(input string name);
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL %s missing=%0d next=%s@%0d required 0 pending",
                     name, sb_q.size(), ev_name(sb_q[0].kind), sb_q[0].cyc);
            sb_q.delete();
        end
    endtask

    task automatic check_all_zero(input string name);
        logic [4:0] outs;
        outs = {key_press, key_release, key_long, key_repeat, key_level};
        checks++;
        if (outs !== 5'b00000) begin
            failures++;
            $display("FAIL %s outputs=%b required 00000", name, outs);
        end
    endtask

    // Returns the cycle of the first edge that sees the new raw level.
    task automatic drive_raw(input logic pressed, output int t);
        @(negedge clk);
        key_raw = ~pressed;
        t = edge_cnt + 1;
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        key_raw = 1'b1;
        repeat (3) @(negedge clk);
        check_all_zero("reset_state");
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check_level("reset_idle_level", 1'b0);
        check_drained("reset_idle");
    endtask

    task automatic test_clean_press();
        int t0;
        int t1;
        drive_raw(1'b1, t0);
        push_ev(EV_PRESS, t0 + 22);
        wait_to(t0 + 21);
        check_level("clean_level_before", 1'b0);
        wait_to(t0 + 22);
        check_level("clean_level_on", 1'b1);
        wait_to(t0 + 59);
        key_raw = 1'b1;
        t1 = t0 + 60;
        push_ev(EV_RELEASE, t1 + 22);
        wait_to(t1 + 21);
        check_level("clean_level_hold", 1'b1);
        wait_to(t1 + 22);
        check_level("clean_level_off", 1'b0);
        wait_to(t1 + 40);
        check_drained("clean_press");
    endtask

    task automatic test_bounce();
        int t0;
        int t1;
        drive_raw(1'b1, t0);
        push_ev(EV_PRESS, t0 + 37);
        wait_to(t0 + 9);
        key_raw = 1'b1;
        wait_to(t0 + 14);
        key_raw = 1'b0;
        wait_to(t0 + 36);
        check_level("bounce_level_before", 1'b0);
        wait_to(t0 + 45);
        drive_raw(1'b0, t1);
        push_ev(EV_RELEASE, t1 + 22);
        wait_to(t1 + 30);
        check_drained("bounce");
    endtask

    task automatic test_glitch();
        int t0;
        drive_raw(1'b1, t0);
        wait_to(t0 + 14);
        key_raw = 1'b1;
        wait_to(t0 + 20);
        check_level("glitch_level_mid", 1'b0);
        wait_to(t0 + 50);
        check_level("glitch_level_end", 1'b0);
        check_drained("glitch");
        // A clean press right after must show full latency, proving the FSM idled.
        drive_raw(1'b1, t0);
        push_ev(EV_PRESS, t0 + 22);
        wait_to(t0 + 30);
        key_raw = 1'b1;
        push_ev(EV_RELEASE, t0 + 31 + 22);
        wait_to(t0 + 60);
        check_drained("glitch_followup");
    endtask

    task automatic test_long_repeat();
        int t0;
        int p;
        drive_raw(1'b1, t0);
        p = t0 + 22;
        push_ev(EV_PRESS, p);
        push_ev(EV_LONG, p + 100);
        push_ev(EV_REPEAT, p + 130);
        push_ev(EV_REPEAT, p + 160);
        wait_to(p + 177);
        key_raw = 1'b1;
        push_ev(EV_RELEASE, p + 200);
        check_level("long_level_held", 1'b1);
        wait_to(p + 220);
        check_drained("long_repeat");
    endtask

    task automatic test_release_bounce();
        int t0;
        int p;
        drive_raw(1'b1, t0);
        p = t0 + 22;
        push_ev(EV_PRESS, p);
        push_ev(EV_LONG, p + 100);
        wait_to(p + 109);
        key_raw = 1'b1;
        wait_to(p + 114);
        key_raw = 1'b0;
        push_ev(EV_REPEAT, p + 147);
        push_ev(EV_REPEAT, p + 177);
        for (int c = p + 112; c <= p + 118; c++) begin
            wait_to(c);
            check_level("rb_level_bounce", 1'b1);
        end
        wait_to(p + 179);
        key_raw = 1'b1;
        push_ev(EV_RELEASE, p + 202);
        wait_to(p + 220);
        check_drained("release_bounce");
    endtask

    task automatic test_reset_mid();
        int t0;
        int r;
        drive_raw(1'b1, t0);
        wait_to(t0 + 12);
        rst_n = 1'b0;
        #1;
        check_all_zero("reset_mid_press_db");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        r = edge_cnt + 1;
        push_ev(EV_PRESS, r + 22);
        push_ev(EV_LONG, r + 122);
        wait_to(r + 151);
        check_level("reset_mid_level_long", 1'b1);
        rst_n = 1'b0;
        #1;
        check_all_zero("reset_mid_long_held");
        repeat (4) @(negedge clk);
        check_all_zero("reset_mid_hold_low");
        rst_n = 1'b1;
        r = edge_cnt + 1;
        push_ev(EV_PRESS, r + 22);
        wait_to(r + 29);
        key_raw = 1'b1;
        push_ev(EV_RELEASE, r + 30 + 22);
        wait_to(r + 70);
        check_drained("reset_mid");
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_glitch();
        test_long_repeat();
        test_release_bounce();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
